cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
Parametrised run controller that replaces the fixed always-on clock-enable divider feeding the single-cycle 16-bit processor. It generates the shared cpu clk_en for the program counter, register file and data memory. Modes: free-run, programmable divide, and single-step. Adds PC breakpoints, pause/resume, a sticky halt state, and a retired-cycle counter.

Parameters:
DIV_WIDTH, 32, width of the divide-ratio input and the prescaler counter
PC_WIDTH, 16, width of the PC compared against breakpoints
NUM_BP, 2, number of PC breakpoint comparators (1..8)
CNT_WIDTH, 32, width of the enabled-cycle counter

Ports:
clk_pi  in  1  system clock
reset_n_pi  in  1  reset; asynchronous, active-low
mode_pi  in  2  0=FREE, 1=DIV, 2=STEP, 3=reserved (treated as FREE)
div_value_pi  in  DIV_WIDTH  DIV mode ratio; 0 is treated as 1
step_pi  in  1  single-step request, level; rising edge is the event
resume_pi  in  1  leave PAUSED, level; rising edge is the event
halt_cmd_pi  in  1  decoder halt indication for the current instruction
pc_pi  in  PC_WIDTH  current PC
bp_addr_pi  in  NUM_BP*PC_WIDTH  breakpoint addresses; slot i = bits [i*PC_WIDTH +: PC_WIDTH]
bp_en_pi  in  NUM_BP  per-slot breakpoint enable
clk_en_po  out  1  cpu clock enable, one clk_pi cycle wide
state_po  out  2  0=RUN, 1=PAUSED, 2=HALTED
bp_hit_po  out  1  sticky; set on breakpoint entry, cleared on resume
bp_index_po  out  3  lowest matching slot index at the last hit
cycle_count_po  out  CNT_WIDTH  number of clk_en_po pulses; saturating

Behaviour:
- Reset, asynchronous, reset_n_pi low: state=RUN, prescaler=0, step/resume edge registers=0, skip flag=0, bp_hit_po=0, bp_index_po=0, cycle_count_po=0. clk_en_po=0 while reset is asserted.
- Prescaler (tick):
  - FREE: tick=1 every cycle.
  - DIV: counter runs 0..N-1, where N=max(div_value_pi,1). tick=1 when counter==0.
  - If counter>=N-1 (including when div_value shrinks mid-count), counter wraps to 0 on the next cycle.
  - A mode_pi change resets the counter to 0.
- Step and resume are detected as rising edges against a registered copy of the input. A request is held pending until consumed, and never queues more than one.
- Breakpoint match (bp_match): any slot i with bp_en_pi[i] && pc_pi==slot i address, qualified by ~skip. Breakpoints are ignored in STEP mode.
- clk_en_po is combinational from registered state plus current inputs:
  - RUN, FREE/DIV: clk_en = tick & ~halt_cmd_pi & ~bp_match.
  - RUN, STEP: clk_en = step_pending & ~halt_cmd_pi. step_pending is consumed in that cycle. Result: exactly one pulse, one cycle after the step_pi rise.
  - PAUSED or HALTED: clk_en=0.
- Transitions, evaluated in priority order halt > breakpoint > resume:
  - RUN to HALTED when halt_cmd_pi=1 on a cycle that would otherwise be enabled (tick, or step pending). HALTED is exited only by reset.
  - RUN to PAUSED when bp_match & tick, in FREE/DIV modes. bp_hit_po is set and bp_index_po latches the lowest matching slot.
  - PAUSED to RUN on a resume edge. Set skip=1 and clear bp_hit_po. skip clears on the next clk_en pulse, so the breakpointed instruction executes exactly once.
  - A resume edge in RUN or HALTED is discarded. A step edge outside STEP mode is discarded.
  - Simultaneous halt_cmd_pi and bp_match: HALTED wins and bp_hit_po stays 0.
- cycle_count_po increments on each clk_en_po pulse and saturates at all-ones.
- bp_en_pi deasserted while PAUSED does not leave PAUSED; only a resume edge does.
- The processor-side gating (clk_en & ~halt) stays in the top level unchanged. This block is a drop-in for the existing clock-enable source.

Decomposition:
- Package cpu_run_pkg holds:
  - mode encodings MODE_FREE/MODE_DIV/MODE_STEP
  - state encodings ST_RUN/ST_PAUSED/ST_HALTED
  - the bp_index_po width constant
- Sub-module run_prescaler: mode, div_value in; tick out. Contains the wrap and mode-change reset logic.
- The breakpoint compare is a generate loop inside cpu_run_ctrl.

Test Plan:
- FREE mode, no halt, run 10 cycles after reset release → clk_en_po high all 10 cycles, cycle_count_po=10.
- DIV, div_value=4 → clk_en_po pulses at cycles 0, 4, 8. Change div_value to 2 while counter=3 → wrap to 0 next cycle, then pulses every 2 cycles. div_value=0 behaves as 1.
- STEP mode, three step_pi rises with step_pi held high 5 cycles each → exactly 3 single-cycle clk_en pulses, each one cycle after its rise, cycle_count_po +3.
- FREE, bp slot1=0x0005 enabled, PC advancing from 0 → clk_en low at PC=5; state_po=PAUSED, bp_hit_po=1, bp_index_po=1. Resume edge → state RUN, one pulse at PC=5, PC advances to 6 without re-pausing.
- halt_cmd_pi asserted while RUN, and in another run together with bp_match → state_po=HALTED, clk_en_po stays 0, bp_hit_po=0. resume_pi and step_pi are ignored. Asserting reset_n_pi low mid-operation (also from PAUSED) returns every output to its reset value asynchronously.

Source files
------------

// File: rtl/cpu_run_pkg.sv
// rtl/cpu_run_pkg.sv - encodings shared by the cpu run controller
package cpu_run_pkg;
   typedef enum logic [1:0] {
      MODE_FREE = 2'd0,
      MODE_DIV  = 2'd1,
      MODE_STEP = 2'd2,
      MODE_RSVD = 2'd3
   } run_mode_e;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_PAUSED = 2'd1,
      ST_HALTED = 2'd2
   } run_state_e;

   localparam int BP_IDX_W = 3;
endpackage

// File: rtl/run_prescaler.sv
// rtl/run_prescaler.sv - divide-ratio tick generator for the run controller
module run_prescaler
   import cpu_run_pkg::*;
#(
   parameter int DIV_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [1:0]           mode,
   input  logic [DIV_WIDTH-1:0] div_value,
   output logic                 tick
);
   logic [DIV_WIDTH-1:0] cnt;
   logic [DIV_WIDTH-1:0] ratio_m1;
   logic                 div_mode;

   assign div_mode = (mode == MODE_DIV);
   assign ratio_m1 = (div_value == '0) ? '0 : div_value - DIV_WIDTH'(1);
   assign tick     = div_mode ? (cnt == '0) : 1'b1;

   // Held at zero outside DIV, so any mode change restarts the count from 0;
   // the >= compare also catches a ratio that shrank below the current count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!div_mode || cnt >= ratio_m1) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + DIV_WIDTH'(1);
      end
   end
endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - cpu clock-enable source with divide, single-step,
// breakpoints, pause/resume, sticky halt and an enabled-cycle counter
module cpu_run_ctrl
   import cpu_run_pkg::*;
#(
   parameter int DIV_WIDTH = 32,
   parameter int PC_WIDTH  = 16,
   parameter int NUM_BP    = 2,
   parameter int CNT_WIDTH = 32
) (
   input  logic                        clk_pi,
   input  logic                        reset_n_pi,
   input  logic [1:0]                  mode_pi,
   input  logic [DIV_WIDTH-1:0]        div_value_pi,
   input  logic                        step_pi,
   input  logic                        resume_pi,
   input  logic                        halt_cmd_pi,
   input  logic [PC_WIDTH-1:0]         pc_pi,
   input  logic [NUM_BP*PC_WIDTH-1:0]  bp_addr_pi,
   input  logic [NUM_BP-1:0]           bp_en_pi,
   output logic                        clk_en_po,
   output logic [1:0]                  state_po,
   output logic                        bp_hit_po,
   output logic [BP_IDX_W-1:0]         bp_index_po,
   output logic [CNT_WIDTH-1:0]        cycle_count_po
);
   run_state_e          state;
   logic                step_q, resume_q, step_pending, skip;
   logic                tick, step_mode, step_rise, resume_rise, would_en, bp_match;
   logic [NUM_BP-1:0]   bp_eq;
   logic [BP_IDX_W-1:0] bp_first;

   run_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_prescaler (
      .clk       (clk_pi),
      .rst_n     (reset_n_pi),
      .mode      (mode_pi),
      .div_value (div_value_pi),
      .tick      (tick)
   );

   for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
      assign bp_eq[i] = bp_en_pi[i] && (pc_pi == bp_addr_pi[i*PC_WIDTH +: PC_WIDTH]);
   end

   always_comb begin
      bp_first = '0;
      for (int k = NUM_BP - 1; k >= 0; k--) begin
         if (bp_eq[k]) bp_first = BP_IDX_W'(k);
      end
   end

   assign step_mode   = (mode_pi == MODE_STEP);
   assign step_rise   = step_pi & ~step_q;
   assign resume_rise = resume_pi & ~resume_q;
   assign bp_match    = (|bp_eq) && !skip && !step_mode;
   assign would_en    = step_mode ? step_pending : tick;
   assign clk_en_po   = reset_n_pi && (state == ST_RUN) && would_en && !halt_cmd_pi && !bp_match;
   assign state_po    = state;

   always_ff @(posedge clk_pi or negedge reset_n_pi) begin
      if (!reset_n_pi) begin
         state          <= ST_RUN;
         step_q         <= 1'b0;
         resume_q       <= 1'b0;
         step_pending   <= 1'b0;
         skip           <= 1'b0;
         bp_hit_po      <= 1'b0;
         bp_index_po    <= '0;
         cycle_count_po <= '0;
      end else begin
         step_q   <= step_pi;
         resume_q <= resume_pi;

         if (clk_en_po && cycle_count_po != '1) cycle_count_po <= cycle_count_po + CNT_WIDTH'(1);
         if (clk_en_po) skip <= 1'b0;

         // A pending step is consumed whether it pulses or is swallowed by a halt.
         if (step_mode && state == ST_RUN) begin
            if (would_en) step_pending <= 1'b0;
            else if (step_rise) step_pending <= 1'b1;
         end else begin
            step_pending <= 1'b0;
         end

         case (state)
            ST_RUN: begin
               if (would_en && halt_cmd_pi) begin
                  state <= ST_HALTED;
               end else if (bp_match && tick) begin
                  state       <= ST_PAUSED;
                  bp_hit_po   <= 1'b1;
                  bp_index_po <= bp_first;
               end
            end
            ST_PAUSED: begin
               if (resume_rise) begin
                  state     <= ST_RUN;
                  skip      <= 1'b1;
                  bp_hit_po <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - directed self-checking bench for cpu_run_ctrl
module tb_cpu_run_ctrl;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  mode;
   logic [31:0] div_value;
   logic        step, resume, halt_cmd;
   logic [15:0] pc;
   logic [31:0] bp_addr;
   logic [1:0]  bp_en;
   logic        clk_en;
   logic [1:0]  state;
   logic        bp_hit;
   logic [2:0]  bp_index;
   logic [31:0] cycle_count;

   int n_tests = 0;
   int n_fail  = 0;
   logic [8:0] bits;

   cpu_run_ctrl dut (
      .clk_pi         (clk),
      .reset_n_pi     (reset_n),
      .mode_pi        (mode),
      .div_value_pi   (div_value),
      .step_pi        (step),
      .resume_pi      (resume),
      .halt_cmd_pi    (halt_cmd),
      .pc_pi          (pc),
      .bp_addr_pi     (bp_addr),
      .bp_en_pi       (bp_en),
      .clk_en_po      (clk_en),
      .state_po       (state),
      .bp_hit_po      (bp_hit),
      .bp_index_po    (bp_index),
      .cycle_count_po (cycle_count)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_n = 1'b0; mode = 2'd0; div_value = 32'd0; step = 1'b0; resume = 1'b0;
      halt_cmd = 1'b0; pc = 16'd0; bp_addr = {16'h0005, 16'h0005}; bp_en = 2'b00;
      #3;
      check("rst_clk_en", 64'(clk_en), 64'd0);
      check("rst_state", 64'(state), 64'd0);
      check("rst_bp_hit", 64'(bp_hit), 64'd0);
      check("rst_bp_index", 64'(bp_index), 64'd0);
      check("rst_count", 64'(cycle_count), 64'd0);

      // FREE: ten enabled cycles
      cyc(); cyc();
      reset_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #1 check("free_en", 64'(clk_en), 64'd1);
         cyc();
      end
      check("free_count", 64'(cycle_count), 64'd10);

      // DIV by 4: pulses on cycles 0, 4, 8
      mode = 2'd1; div_value = 32'd4;
      for (int c = 0; c < 9; c++) begin
         #1 bits[c] = clk_en;
         cyc();
      end
      check("div4_pattern", 64'(bits), 64'h111);
      cyc(); cyc();
      // counter now 3: shrink ratio to 2, wrap then pulse every other cycle
      div_value = 32'd2;
      bits = '0;
      for (int c = 0; c < 5; c++) begin
         #1 bits[c] = clk_en;
         cyc();
      end
      check("div2_pattern", 64'(bits[4:0]), 64'h0A);
      check("div_count", 64'(cycle_count), 64'd15);
      div_value = 32'd0;
      bits = '0;
      for (int c = 0; c < 4; c++) begin
         #1 bits[c] = clk_en;
         cyc();
      end
      check("div0_pattern", 64'(bits[3:0]), 64'hF);
      check("div0_count", 64'(cycle_count), 64'd19);

      // STEP: three rises held five cycles each
      mode = 2'd2;
      for (int r = 0; r < 3; r++) begin
         bits = '0;
         for (int c = 0; c < 8; c++) begin
            step = (c < 5);
            #1 bits[c] = clk_en;
            cyc();
         end
         check("step_pattern", 64'(bits[7:0]), 64'h02);
      end
      check("step_count", 64'(cycle_count), 64'd22);

      // Breakpoint on slot 1 at PC 5 (slot 0 has same address but disabled)
      mode = 2'd0; bp_en = 2'b10;
      for (int p = 0; p < 5; p++) begin
         pc = 16'(p);
         #1 check("bp_run_en", 64'(clk_en), 64'd1);
         cyc();
      end
      pc = 16'd5;
      #1 check("bp_gate_en", 64'(clk_en), 64'd0);
      cyc();
      check("bp_state", 64'(state), 64'd1);
      check("bp_hit", 64'(bp_hit), 64'd1);
      check("bp_index", 64'(bp_index), 64'd1);
      bp_en = 2'b00;
      cyc(); cyc();
      check("bp_en_off_state", 64'(state), 64'd1);
      check("paused_en", 64'(clk_en), 64'd0);
      bp_en = 2'b10;
      resume = 1'b1;
      cyc();
      check("resume_state", 64'(state), 64'd0);
      check("resume_bp_hit", 64'(bp_hit), 64'd0);
      check("resume_en_pc5", 64'(clk_en), 64'd1);
      cyc();
      pc = 16'd6;
      #1 check("pc6_en", 64'(clk_en), 64'd1);
      cyc();
      check("pc6_state", 64'(state), 64'd0);
      check("bp_count", 64'(cycle_count), 64'd29);

      // Halt from RUN, then resume/step ignored
      pc = 16'd7; halt_cmd = 1'b1; resume = 1'b0;
      #1 check("halt_en", 64'(clk_en), 64'd0);
      cyc();
      halt_cmd = 1'b0;
      check("halt_state", 64'(state), 64'd2);
      check("halt_count", 64'(cycle_count), 64'd29);
      resume = 1'b1;
      cyc();
      mode = 2'd2; step = 1'b0;
      cyc();
      step = 1'b1;
      cyc(); cyc();
      check("halt_sticky_state", 64'(state), 64'd2);
      check("halt_sticky_en", 64'(clk_en), 64'd0);
      check("halt_bp_hit", 64'(bp_hit), 64'd0);
      reset_n = 1'b0;
      #1;
      check("async_rst_state", 64'(state), 64'd0);
      check("async_rst_count", 64'(cycle_count), 64'd0);
      check("async_rst_en", 64'(clk_en), 64'd0);

      // Halt together with a breakpoint match
      step = 1'b0; resume = 1'b0; mode = 2'd0; pc = 16'd5; halt_cmd = 1'b1;
      cyc();
      reset_n = 1'b1;
      #1 check("halt_bp_en", 64'(clk_en), 64'd0);
      cyc();
      halt_cmd = 1'b0;
      check("halt_bp_state", 64'(state), 64'd2);
      check("halt_bp_hit", 64'(bp_hit), 64'd0);
      check("halt_bp_index", 64'(bp_index), 64'd0);

      // Reset out of PAUSED
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
      pc = 16'd3;
      cyc(); cyc();
      pc = 16'd5;
      cyc();
      check("pause2_state", 64'(state), 64'd1);
      check("pause2_count", 64'(cycle_count), 64'd2);
      reset_n = 1'b0;
      #1;
      check("prst_state", 64'(state), 64'd0);
      check("prst_bp_hit", 64'(bp_hit), 64'd0);
      check("prst_count", 64'(cycle_count), 64'd0);
      check("prst_en", 64'(clk_en), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
